gfx_strip_reader: RTL and testbench

Frame-buffer read engine. It fetches 128-bit strips from graphics memory and unpacks them into a pixel stream according to the colour depth. It is the read counterpart of the frame-buffer write engine's LOADSTRIP/STORESTRIP path, and it feeds the display/blit pipeline with one raw pixel per handshake. It sits between the memory bus master port and any pixel consumer.

---
 rtl/gfx_pkg.sv | 34 +++
 rtl/gfx_pixel_extract.sv | 34 +++
 rtl/gfx_strip_reader.sv | 212 +++++++++++++++++++++
 tb/tb_gfx_strip_reader.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared graphics types and constants used by the frame-buffer engines.
package gfx_pkg;

    localparam int unsigned address_width = 32;
    localparam int unsigned STRIP_BYTES   = 16;
    localparam int unsigned STRIP_BITS    = 128;
    localparam int unsigned PIX_W         = 32;
    localparam int unsigned IDX_W         = 5;

    typedef enum logic [1:0] {
        BPP8  = 2'd0,
        BPP16 = 2'd1,
        BPP24 = 2'd2,
        BPP32 = 2'd3
    } color_depth_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_REQ    = 2'd1,
        RD_UNPACK = 2'd2,
        RD_DONE   = 2'd3
    } rd_state_t;

    // Number of whole pixels held in one 128-bit strip.
    function automatic logic [IDX_W-1:0] pixels_per_strip(input color_depth_t depth);
        case (depth)
            BPP8:    return IDX_W'(16);
            BPP16:   return IDX_W'(8);
            BPP24:   return IDX_W'(5);
            default: return IDX_W'(4);
        endcase
    endfunction

endpackage

// File: rtl/gfx_pixel_extract.sv
// Selects one pixel field out of a strip and zero-extends it to 32 bits.
module gfx_pixel_extract
    import gfx_pkg::*;
(
    input  logic [STRIP_BITS-1:0] strip_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  color_depth_t          depth_i,
    output logic [PIX_W-1:0]      pix_c
);

    // Constant-offset field mux per depth; out-of-range indices yield 0.
    always_comb begin
        pix_c = '0;
        case (depth_i)
            BPP8: begin
                for (int i = 0; i < 16; i++)
                    if (idx_i == IDX_W'(i)) pix_c = PIX_W'(strip_i[8*i +: 8]);
            end
            BPP16: begin
                for (int i = 0; i < 8; i++)
                    if (idx_i == IDX_W'(i)) pix_c = PIX_W'(strip_i[16*i +: 16]);
            end
            BPP24: begin
                for (int i = 0; i < 5; i++)
                    if (idx_i == IDX_W'(i)) pix_c = PIX_W'(strip_i[24*i +: 24]);
            end
            default: begin
                for (int i = 0; i < 4; i++)
                    if (idx_i == IDX_W'(i)) pix_c = strip_i[32*i +: 32];
            end
        endcase
    end

endmodule

// File: rtl/gfx_strip_reader.sv
// Frame-buffer read engine: fetches 128-bit strips and streams raw pixels.
// Optional: define GFX_STRIP_PREFETCH_EN for a second strip buffer that is
// filled while the current strip is being unpacked.
module gfx_strip_reader
    import gfx_pkg::*;
#(
    parameter int unsigned STRIP_W = 128,
    parameter int unsigned AW      = address_width
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [AW-1:0]      base_adr_i,
    input  logic [15:0]        pix_count_i,
    input  color_depth_t       color_depth_i,
    output logic               m_cyc_o,
    output logic               m_stb_o,
    output logic [AW-1:0]      m_adr_o,
    input  logic               m_ack_i,
    input  logic [STRIP_W-1:0] m_dat_i,
    output logic               pix_valid_o,
    input  logic               pix_ready_i,
    output logic [PIX_W-1:0]   pix_o,
    output logic               busy_o,
    output logic               done_o
);

    rd_state_t          state_q, state_d;
    logic [AW-1:0]      adr_q, adr_d;
    logic [15:0]        cnt_q, cnt_d;
    color_depth_t       depth_q, depth_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [STRIP_W-1:0] buf_q, buf_d;
    logic               cyc_q, cyc_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [PIX_W-1:0]   pix_q, pix_d;

    logic [PIX_W-1:0]   pix_next_c;
    logic [IDX_W-1:0]   pps_c;
    logic               hs_c;
    logic               last_pix_c;
    logic               strip_end_c;
    logic               unused_adr_lsb_c;

`ifdef GFX_STRIP_PREFETCH_EN
    logic [STRIP_W-1:0] pbuf_q, pbuf_d;
    logic               pvalid_q, pvalid_d;
    logic               more_c;
`endif

    assign pps_c            = pixels_per_strip(depth_q);
    assign hs_c             = valid_q && pix_ready_i;
    assign last_pix_c       = (cnt_q == 16'd1);
    assign strip_end_c      = ((idx_q + IDX_W'(1)) == pps_c);
    assign unused_adr_lsb_c = ^base_adr_i[3:0];
`ifdef GFX_STRIP_PREFETCH_EN
    // More pixels remain than the current strip still holds.
    assign more_c           = (cnt_q > 16'(pps_c - idx_q));
`endif

    // Pixel field for the next cycle's buffer/index, registered into pix_q.
    gfx_pixel_extract u_extract (
        .strip_i (buf_d),
        .idx_i   (idx_d),
        .depth_i (depth_d),
        .pix_c   (pix_next_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        depth_d = depth_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        cyc_d   = cyc_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef GFX_STRIP_PREFETCH_EN
        pbuf_d   = pbuf_q;
        pvalid_d = pvalid_q;
`endif
        case (state_q)
            RD_IDLE: begin
                if (start_i) begin
                    adr_d   = {base_adr_i[AW-1:4], 4'b0000};
                    cnt_d   = pix_count_i;
                    depth_d = color_depth_i;
                    busy_d  = 1'b1;
                    if (pix_count_i == 16'd0) begin
                        state_d = RD_DONE;
                    end else begin
                        state_d = RD_REQ;
                        cyc_d   = 1'b1;
                    end
                end
            end
            RD_REQ: begin
                cyc_d = 1'b1;
                if (m_ack_i) begin
                    buf_d   = m_dat_i;
                    idx_d   = '0;
                    adr_d   = adr_q + AW'(STRIP_BYTES);
                    cyc_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = RD_UNPACK;
                end
            end
            RD_UNPACK: begin
`ifdef GFX_STRIP_PREFETCH_EN
                if (cyc_q && m_ack_i) begin
                    pbuf_d   = m_dat_i;
                    pvalid_d = 1'b1;
                    cyc_d    = 1'b0;
                    adr_d    = adr_q + AW'(STRIP_BYTES);
                end else if (!cyc_q && !pvalid_q && more_c) begin
                    cyc_d = 1'b1;
                end
`endif
                if (hs_c) begin
                    cnt_d = cnt_q - 16'd1;
                    idx_d = idx_q + IDX_W'(1);
                    if (last_pix_c) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = RD_DONE;
                    end else if (strip_end_c) begin
`ifdef GFX_STRIP_PREFETCH_EN
                        if (pvalid_q) begin
                            buf_d    = pbuf_q;
                            pvalid_d = 1'b0;
                            idx_d    = '0;
                        end else if (cyc_q && m_ack_i) begin
                            buf_d    = m_dat_i;
                            pvalid_d = 1'b0;
                            idx_d    = '0;
                        end else begin
                            // Request is pending or not yet issued; RD_REQ keeps the same address.
                            valid_d = 1'b0;
                            cyc_d   = 1'b1;
                            state_d = RD_REQ;
                        end
`else
                        valid_d = 1'b0;
                        cyc_d   = 1'b1;
                        state_d = RD_REQ;
`endif
                    end
                end
            end
            RD_DONE: begin
                // The normal path pulsed done on entry; a zero-count start pulses it here.
                done_d  = !done_q;
                busy_d  = 1'b0;
                state_d = RD_IDLE;
            end
            default: state_d = RD_IDLE;
        endcase
        pix_d = (state_d == RD_UNPACK) ? pix_next_c : '0;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= RD_IDLE;
            adr_q    <= '0;
            cnt_q    <= '0;
            depth_q  <= BPP8;
            idx_q    <= '0;
            buf_q    <= '0;
            cyc_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pix_q    <= '0;
`ifdef GFX_STRIP_PREFETCH_EN
            pbuf_q   <= '0;
            pvalid_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            cnt_q    <= cnt_d;
            depth_q  <= depth_d;
            idx_q    <= idx_d;
            buf_q    <= buf_d;
            cyc_q    <= cyc_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pix_q    <= pix_d;
`ifdef GFX_STRIP_PREFETCH_EN
            pbuf_q   <= pbuf_d;
            pvalid_q <= pvalid_d;
`endif
        end
    end

    assign m_cyc_o     = cyc_q;
    assign m_stb_o     = cyc_q;
    assign m_adr_o     = adr_q;
    assign pix_valid_o = valid_q;
    assign pix_o       = pix_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_gfx_strip_reader.sv
// Self-checking bench for gfx_strip_reader: memory responder, ready pattern
// driver, per-cycle compare against an arithmetic pixel model, directed tests.
module tb_gfx_strip_reader;
    import gfx_pkg::*;

    localparam int unsigned AW = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] base_adr_i;
    logic [15:0]   pix_count_i;
    color_depth_t  color_depth_i;
    logic          m_cyc_o, m_stb_o;
    logic [AW-1:0] m_adr_o;
    logic          m_ack_i;
    logic [127:0]  m_dat_i;
    logic          pix_valid_o;
    logic          pix_ready_i;
    logic [31:0]   pix_o;
    logic          busy_o;
    logic          done_o;

    gfx_strip_reader dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .base_adr_i    (base_adr_i),
        .pix_count_i   (pix_count_i),
        .color_depth_i (color_depth_i),
        .m_cyc_o       (m_cyc_o),
        .m_stb_o       (m_stb_o),
        .m_adr_o       (m_adr_o),
        .m_ack_i       (m_ack_i),
        .m_dat_i       (m_dat_i),
        .pix_valid_o   (pix_valid_o),
        .pix_ready_i   (pix_ready_i),
        .pix_o         (pix_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc_n = 0;
    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    int checks = 0;
    int errors = 0;

    // Test configuration (written by the main sequence only).
    int           test_id   = 0;
    color_depth_t cfg_depth = BPP8;
    int           cfg_count = 0;
    int           lat       = 1;
    logic         force_ack = 1'b0;
    logic [127:0] strips [4];
    logic         rdy_pat [4];
    int           rdy_len   = 1;

    // Memory-side log (written by the responder only).
    logic [AW-1:0] rd_q [$];
    int            rd_idx = 0;

    // Monitor statistics (written by the compare process only).
    logic [31:0] rx_q [$];
    int   hs_total = 0, stalls = 0, vcycles = 0;
    int   first_v_cyc = -1, last_hs_cyc = -1;
    int   done_seen = 0, done_cyc = -1, cyc_seen = 0;
    logic prev_stall = 1'b0, prev_done = 1'b0;
    logic [31:0] prev_pix = '0;
    int   cmp_id = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Pixel n of the transfer, straight from the strip layout rules.
    function automatic logic [31:0] model_pix(input int n);
        int bits, pps, k, i;
        logic [127:0] s;
        case (cfg_depth)
            BPP8:    bits = 8;
            BPP16:   bits = 16;
            BPP24:   bits = 24;
            default: bits = 32;
        endcase
        pps = 128 / bits;
        k   = n / pps;
        i   = n % pps;
        s   = (k < 4) ? strips[k] : '0;
        s   = (s >> (i * bits)) & ((128'd1 << bits) - 128'd1);
        return s[31:0];
    endfunction

    // Memory responder and consumer-ready driver.
    int env_id = 0, wait_n = 0, vcnt = 0;
    initial begin
        m_ack_i     = 1'b0;
        m_dat_i     = '0;
        pix_ready_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (test_id != env_id) begin
                env_id = test_id;
                vcnt   = 0;
                rd_idx = 0;
                rd_q.delete();
            end
            pix_ready_i = rdy_pat[vcnt % rdy_len];
            if (pix_valid_o) vcnt++;
            if (m_ack_i) begin
                m_ack_i = 1'b0;
                wait_n  = 0;
            end else if (m_cyc_o && rst_ni) begin
                wait_n++;
                if (wait_n >= lat) begin
                    m_ack_i = 1'b1;
                    m_dat_i = (rd_idx < 4) ? strips[rd_idx] : '0;
                    rd_q.push_back(m_adr_o);
                    rd_idx++;
                    wait_n = 0;
                end
            end else begin
                wait_n = 0;
            end
            if (force_ack) m_ack_i = 1'b1;
        end
    end

    // Per-cycle compare against the model.
    initial begin
        forever begin
            @(negedge clk_i);
            if (test_id != cmp_id) begin
                cmp_id      = test_id;
                hs_total    = 0;
                stalls      = 0;
                vcycles     = 0;
                first_v_cyc = -1;
                last_hs_cyc = -1;
                done_seen   = 0;
                done_cyc    = -1;
                cyc_seen    = 0;
                rx_q.delete();
                prev_stall  = 1'b0;
            end
            if (!rst_ni) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
            end else begin
                if (m_cyc_o) begin
                    cyc_seen++;
                    check("stb_eq_cyc", 64'(m_stb_o), 64'(1));
                    check("adr_align", 64'(m_adr_o[3:0]), 64'(0));
                end
                if (prev_stall) begin
                    check("hold_valid", 64'(pix_valid_o), 64'(1));
                    check("hold_pix", 64'(pix_o), 64'(prev_pix));
                end
                if (pix_valid_o) begin
                    vcycles++;
                    if (first_v_cyc < 0) first_v_cyc = cyc_n;
                    if (!pix_ready_i) stalls++;
                end
                if (pix_valid_o && pix_ready_i) begin
                    if (hs_total >= cfg_count) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_pixel actual=0x%0h required=none", pix_o);
                    end else begin
                        check($sformatf("pixel[%0d]", hs_total), 64'(pix_o), 64'(model_pix(hs_total)));
                    end
                    rx_q.push_back(pix_o);
                    hs_total++;
                    last_hs_cyc = cyc_n;
                end
                if (done_o) begin
                    done_seen++;
                    done_cyc = cyc_n;
                    check("busy_low_at_done", 64'(busy_o), 64'(0));
                    check("done_single", 64'(prev_done), 64'(0));
                    if (cfg_count > 0)
                        check("done_after_last", 64'(cyc_n), 64'(last_hs_cyc + 1));
                end
                prev_stall = pix_valid_o && !pix_ready_i;
                prev_pix   = pix_o;
                prev_done  = done_o;
            end
        end
    end

    function automatic logic [31:0] rx_at(input int j);
        return (rx_q.size() > j) ? rx_q[j] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rd_at(input int j);
        return (rd_q.size() > j) ? rd_q[j] : 32'hDEAD_BEEF;
    endfunction

    task automatic new_test(input color_depth_t d, input int cnt, input int l);
        @(negedge clk_i);
        cfg_depth = d;
        cfg_count = cnt;
        lat       = l;
        test_id++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_xfer(input color_depth_t d, input logic [31:0] base, input int cnt);
        @(posedge clk_i);
        #1;
        color_depth_i = d;
        base_adr_i    = base;
        pix_count_i   = 16'(cnt);
        start_i       = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n = 0;
        while (done_seen == 0 && n < budget) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        repeat (4) @(negedge clk_i);
        #1;
        check({nm, "_done_count"}, 64'(done_seen), 64'(1));
        check({nm, "_idle_busy"}, 64'(busy_o), 64'(0));
    endtask

    task automatic all_ready();
        for (int i = 0; i < 4; i++) rdy_pat[i] = 1'b1;
        rdy_len = 1;
    endtask

    int s_cyc;
    int aa_bytes;

    initial begin
        rst_ni        = 1'b0;
        start_i       = 1'b0;
        base_adr_i    = '0;
        pix_count_i   = '0;
        color_depth_i = BPP8;
        all_ready();
        for (int k = 0; k < 4; k++) strips[k] = '0;

        // Reset values.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_cyc", 64'(m_cyc_o), 64'(0));
        check("rst_stb", 64'(m_stb_o), 64'(0));
        check("rst_adr", 64'(m_adr_o), 64'(0));
        check("rst_valid", 64'(pix_valid_o), 64'(0));
        check("rst_pix", 64'(pix_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Basic BPP8: 20 pixels over two strips.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 16; i++) strips[k][8*i +: 8] = 8'(16 * k + i);
        new_test(BPP8, 20, 2);
        start_xfer(BPP8, 32'h0000_1000, 20);
        check("b8_busy_after_start", 64'(busy_o), 64'(1));
        check("b8_cyc_after_start", 64'(m_cyc_o), 64'(1));
        wait_done("b8", 300);
        check("b8_hs", 64'(hs_total), 64'(20));
        check("b8_reads", 64'(rd_q.size()), 64'(2));
        check("b8_rd0", 64'(rd_at(0)), 64'(32'h1000));
        check("b8_rd1", 64'(rd_at(1)), 64'(32'h1010));
        check("b8_px0", 64'(rx_at(0)), 64'(32'h00));
        check("b8_px19", 64'(rx_at(19)), 64'(32'h13));

        // BPP24: top byte of each strip is discarded; unaligned base.
        for (int k = 0; k < 4; k++) strips[k] = '0;
        for (int i = 0; i < 15; i++) strips[0][8*i +: 8] = 8'(32 + i);
        strips[0][127:120] = 8'hAA;
        for (int i = 0; i < 16; i++) strips[1][8*i +: 8] = 8'(64 + i);
        new_test(BPP24, 6, 3);
        start_xfer(BPP24, 32'h0000_2007, 6);
        wait_done("b24", 300);
        check("b24_hs", 64'(hs_total), 64'(6));
        check("b24_rd0", 64'(rd_at(0)), 64'(32'h2000));
        check("b24_rd1", 64'(rd_at(1)), 64'(32'h2010));
        check("b24_px0", 64'(rx_at(0)), 64'(32'h0022_2120));
        check("b24_px4", 64'(rx_at(4)), 64'(32'h002E_2D2C));
        check("b24_px5", 64'(rx_at(5)), 64'(32'h0042_4140));
        aa_bytes = 0;
        for (int j = 0; j < rx_q.size(); j++)
            for (int b = 0; b < 4; b++)
                if (rx_q[j][8*b +: 8] == 8'hAA) aa_bytes++;
        check("b24_no_aa", 64'(aa_bytes), 64'(0));

        // BPP32 backpressure: ready follows 1,0,0,1 over valid cycles.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) strips[k][32*i +: 32] = 32'hC0DE_0000 + 32'(16 * k + i);
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        rdy_len = 4;
        new_test(BPP32, 4, 2);
        start_xfer(BPP32, 32'h0000_3000, 4);
        wait_done("bp", 300);
        check("bp_hs", 64'(hs_total), 64'(4));
        check("bp_stalls", 64'(stalls), 64'(4));
        check("bp_reads", 64'(rd_q.size()), 64'(1));
        check("bp_px3", 64'(rx_at(3)), 64'(32'hC0DE_0003));
        all_ready();

        // Zero count, with start held into the RD_DONE cycle.
        new_test(BPP8, 0, 1);
        @(posedge clk_i);
        #1;
        color_depth_i = BPP8;
        base_adr_i    = 32'h0000_5000;
        pix_count_i   = 16'd0;
        start_i       = 1'b1;
        s_cyc         = cyc_n;
        @(posedge clk_i);
        #1;
        check("zero_busy", 64'(busy_o), 64'(1));
        check("zero_no_cyc_1", 64'(m_cyc_o), 64'(0));
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done("zero", 50);
        check("zero_done_cycle", 64'(done_cyc), 64'(s_cyc + 2));
        check("zero_no_bus", 64'(cyc_seen), 64'(0));
        check("zero_hs", 64'(hs_total), 64'(0));

        // Reset while a bus request is waiting for ack.
        new_test(BPP8, 20, 40);
        start_xfer(BPP8, 32'h0000_6000, 20);
        @(posedge clk_i);
        #1;
        check("rmid_cyc_before", 64'(m_cyc_o), 64'(1));
        @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("rmid_cyc", 64'(m_cyc_o), 64'(0));
        check("rmid_stb", 64'(m_stb_o), 64'(0));
        check("rmid_adr", 64'(m_adr_o), 64'(0));
        check("rmid_valid", 64'(pix_valid_o), 64'(0));
        check("rmid_pix", 64'(pix_o), 64'(0));
        check("rmid_busy", 64'(busy_o), 64'(0));
        check("rmid_done", 64'(done_o), 64'(0));
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        force_ack = 1'b1;
        @(negedge clk_i);
        force_ack = 1'b0;
        repeat (5) @(negedge clk_i);
        #1;
        check("rmid_late_ack_valid", 64'(vcycles), 64'(0));
        check("rmid_late_ack_busy", 64'(busy_o), 64'(0));
        check("rmid_late_ack_cyc", 64'(m_cyc_o), 64'(0));

        // Strip boundary at BPP32, ack latency 1.
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 4; i++) strips[k][32*i +: 32] = 32'h5000_0000 + 32'(16 * k + i);
        new_test(BPP32, 8, 1);
        start_xfer(BPP32, 32'h0000_7000, 8);
        wait_done("pf", 300);
        check("pf_hs", 64'(hs_total), 64'(8));
        check("pf_reads", 64'(rd_q.size()), 64'(2));
        check("pf_rd1", 64'(rd_at(1)), 64'(32'h7010));
        check("pf_px4", 64'(rx_at(4)), 64'(32'h5000_0010));
        check("pf_px7", 64'(rx_at(7)), 64'(32'h5000_0013));
`ifdef GFX_STRIP_PREFETCH_EN
        check("pf_span", 64'(last_hs_cyc - first_v_cyc), 64'(7));
        check("pf_valid_cycles", 64'(vcycles), 64'(8));
`else
        check("nopf_span", 64'(last_hs_cyc - first_v_cyc), 64'(8));
        check("nopf_valid_cycles", 64'(vcycles), 64'(8));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
